// File: rtl/instr_rom_arbiter.sv
// rtl/instr_rom_arbiter.sv - two-port arbiter in front of a combinational-read instruction ROM
//
// Port 0 is the CPU fetch path, port 1 the debug/trace reader. One grant per
// cycle, issued combinationally; read data is registered and appears on the
// cycle after the grant.
//
// Build option: define INSTR_ROM_ARB_RR_EN for round-robin arbitration.
// Without it, port 0 has fixed priority and a starvation counter forces a
// port 1 win after STARVE_MAX consecutive denied cycles.

module instr_rom_arbiter #(
  parameter int          SIZE       = 64,
  parameter int          ADDR_W     = $clog2(SIZE),
  parameter int          STARVE_MAX = 4,
  parameter logic [31:0] FILL_WORD  = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,

  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,

  output logic [ADDR_W-1:0] rom_a,
  input  logic [31:0]       rom_rd
);

  // Response registers, one set per port.
  logic        m0_rvalid_q, m0_rvalid_d;
  logic        m1_rvalid_q, m1_rvalid_d;
  logic [31:0] m0_rdata_q,  m0_rdata_d;
  logic [31:0] m1_rdata_q,  m1_rdata_d;

  // Zero-extended ROM address so the bounds check is a full-width compare;
  // it only ever rejects anything when SIZE is not a power of two.
  logic [31:0] addr_ext;
  logic        in_range;
  logic [31:0] rd_word;

`ifdef INSTR_ROM_ARB_RR_EN

  // prio_q names the port that wins when both request: 0 = port 0, 1 = port 1.
  // After every grant it flips to the port that was not just served.
  logic prio_q, prio_d;

  // Round-robin grant: port 0 wins unless port 1 is also requesting and holds priority.
  always_comb begin
    m0_gnt = m0_req & ~rst & (~m1_req | ~prio_q);
    m1_gnt = m1_req & ~rst & ~m0_gnt;
  end

  // Priority moves to the other port whenever a grant is issued.
  always_comb begin
    prio_d = prio_q;
    if (m0_gnt) begin
      prio_d = 1'b1;
    end else if (m1_gnt) begin
      prio_d = 1'b0;
    end
  end

  // Priority pointer register; port 0 is preferred out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

`else

  // Number of consecutive cycles port 1 has been requesting without a grant,
  // saturating at STARVE_MAX. Reaching the limit hands port 1 the next grant.
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_q, starve_d;
  logic       force1;

  // Port 1 is forced through once it has waited STARVE_MAX cycles.
  always_comb begin
    force1 = (starve_q == STARVE_LIM) & m1_req;
  end

  // Fixed-priority grant with the starvation override; nothing granted in reset.
  always_comb begin
    m0_gnt = m0_req & ~force1 & ~rst;
    m1_gnt = m1_req & ~m0_gnt & ~rst;
  end

  // Count denied port 1 cycles; a grant or a dropped request starts over.
  always_comb begin
    starve_d = starve_q;
    if (!m1_req || m1_gnt) begin
      starve_d = 4'd0;
    end else if (starve_q != STARVE_LIM) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end

`endif

  // ROM address follows the granted port; port 0's address when idle keeps it deterministic.
  always_comb begin
    rom_a = m1_gnt ? m1_addr : m0_addr;
  end

  // Out-of-range words read back as FILL_WORD instead of whatever the ROM drives.
  always_comb begin
    addr_ext               = '0;
    addr_ext[ADDR_W-1:0]   = rom_a;
    in_range               = (addr_ext < 32'(SIZE));
    rd_word                = in_range ? rom_rd : FILL_WORD;
  end

  // Next response state: the granted port captures the word, rdata otherwise holds.
  always_comb begin
    m0_rvalid_d = m0_gnt;
    m1_rvalid_d = m1_gnt;
    m0_rdata_d  = m0_gnt ? rd_word : m0_rdata_q;
    m1_rdata_d  = m1_gnt ? rd_word : m1_rdata_q;
  end

  // Response registers; reset also drops any grant issued in the reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= 32'd0;
      m1_rdata_q  <= 32'd0;
    end else begin
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  // Drive the registered responses out.
  always_comb begin
    m0_rvalid = m0_rvalid_q;
    m1_rvalid = m1_rvalid_q;
    m0_rdata  = m0_rdata_q;
    m1_rdata  = m1_rdata_q;
  end

endmodule

// File: tb/tb_instr_rom_arbiter.sv
// tb/tb_instr_rom_arbiter.sv - self-checking bench for instr_rom_arbiter (SIZE=48)

module tb_instr_rom_arbiter;

  localparam int SIZE = 48;
  localparam int AW   = 6;

  logic          clk;
  logic          rst;
  logic          m0_req;
  logic [AW-1:0] m0_addr;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [31:0]   m0_rdata;
  logic          m1_req;
  logic [AW-1:0] m1_addr;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [31:0]   m1_rdata;
  logic [AW-1:0] rom_a;
  logic [31:0]   rom_rd;

  instr_rom_arbiter #(.SIZE(SIZE)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_addr   (m0_addr),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_addr   (m1_addr),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .rom_a     (rom_a),
    .rom_rd    (rom_rd)
  );

  // ROM model: addi x1, x0, <addr>; defined for every address so out-of-range reads are visible.
  function automatic logic [31:0] rom_fn(input logic [AW-1:0] a);
    logic [31:0] w;
    w = 32'h00000093;
    w[25:20] = a;
    return w;
  endfunction

  function automatic logic [31:0] exp_word(input logic [AW-1:0] a);
    if (int'(a) < SIZE) return rom_fn(a);
    return 32'h00000013;
  endfunction

  assign rom_rd = rom_fn(rom_a);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          r0;
    logic [AW-1:0] a0;
    logic          r1;
    logic [AW-1:0] a1;
    logic          g0;
    logic          g1;
    logic          chk;
  } vec_t;

  typedef struct {
    logic        v0;
    logic        v1;
    logic [31:0] d0;
    logic [31:0] d1;
  } resp_t;

  vec_t  tbl[$];
  resp_t sb[$];
  int    n_cmp;
  int    n_bad;
  logic [31:0] md0;
  logic [31:0] md1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic void add(input logic rs, input logic r0, input int a0, input logic r1,
                              input int a1, input logic g0, input logic g1, input logic chk);
    vec_t v;
    v.rst = rs; v.r0 = r0; v.a0 = AW'(a0); v.r1 = r1; v.a1 = AW'(a1);
    v.g0 = g0; v.g1 = g1; v.chk = chk;
    tbl.push_back(v);
  endfunction

  // One cycle: drive, check last cycle's response from the scoreboard, check grants, push expectation.
  task automatic step(input vec_t v);
    resp_t e;
    resp_t n;
    @(negedge clk);
    rst = v.rst; m0_req = v.r0; m0_addr = v.a0; m1_req = v.r1; m1_addr = v.a1;
    #1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      e = sb.pop_front();
      if (v.chk) begin
        cmp("m0_rvalid", 32'(m0_rvalid), 32'(e.v0));
        cmp("m1_rvalid", 32'(m1_rvalid), 32'(e.v1));
        cmp("m0_rdata", m0_rdata, e.d0);
        cmp("m1_rdata", m1_rdata, e.d1);
      end
    end
    cmp("m0_gnt", 32'(m0_gnt), 32'(v.g0));
    cmp("m1_gnt", 32'(m1_gnt), 32'(v.g1));
    cmp("rom_a", 32'(rom_a), 32'(v.g1 ? v.a1 : v.a0));
    if (v.rst) begin
      md0 = 32'd0;
      md1 = 32'd0;
      n.v0 = 1'b0;
      n.v1 = 1'b0;
    end else begin
      if (v.g0) md0 = exp_word(v.a0);
      if (v.g1) md1 = exp_word(v.a1);
      n.v0 = v.g0;
      n.v1 = v.g1;
    end
    n.d0 = md0;
    n.d1 = md1;
    sb.push_back(n);
  endtask

  task automatic run_table();
    foreach (tbl[i]) step(tbl[i]);
    tbl.delete();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    md0 = 32'd0;
    md1 = 32'd0;
    rst = 1'b1; m0_req = 1'b0; m0_addr = '0; m1_req = 1'b0; m1_addr = '0;
    sb.push_back('{1'b0, 1'b0, 32'd0, 32'd0});

    // Reset with both requesting, then idle: no grants, rvalid/rdata zero.
    add(1, 1, 5, 1, 7, 0, 0, 0);
    add(1, 1, 5, 1, 7, 0, 0, 1);
    add(0, 0, 9, 0, 0, 0, 0, 1);
    // Port 0 alone at address 5.
    add(0, 1, 5, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    // Out of range on port 1, then range boundaries on both ports.
    add(0, 0, 0, 1, 50, 0, 1, 1);
    add(0, 0, 0, 1, 47, 0, 1, 1);
    add(0, 1, 48, 0, 0, 1, 0, 1);
    add(0, 1, 63, 0, 0, 1, 0, 1);
    add(0, 1, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
`ifndef INSTR_ROM_ARB_RR_EN
    // Contention: starvation guard forces port 1 on the fifth cycle.
    add(0, 1, 10, 1, 20, 1, 0, 1);
    add(0, 1, 11, 1, 20, 1, 0, 1);
    add(0, 1, 12, 1, 20, 1, 0, 1);
    add(0, 1, 13, 1, 20, 1, 0, 1);
    add(0, 1, 14, 1, 20, 0, 1, 1);
    add(0, 1, 14, 1, 21, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    // Interleaved: m0 on 0,1,2, m1 on 3 joining at cycle 2.
    add(0, 1, 0, 0, 0, 1, 0, 1);
    add(0, 1, 1, 0, 0, 1, 0, 1);
    add(0, 1, 2, 1, 3, 1, 0, 1);
    add(0, 0, 0, 1, 3, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
`endif
    run_table();

`ifndef INSTR_ROM_ARB_RR_EN
    // Dropped port 1 request must clear the counter: four more port 0 wins before the force.
    step('{1'b0, 1'b1, 6'd30, 1'b1, 6'd40, 1'b1, 1'b0, 1'b1});
    step('{1'b0, 1'b1, 6'd31, 1'b1, 6'd40, 1'b1, 1'b0, 1'b1});
    step('{1'b0, 1'b1, 6'd32, 1'b0, 6'd40, 1'b1, 1'b0, 1'b1});
    for (int i = 0; i < 4; i++)
      step('{1'b0, 1'b1, 6'(33 + i), 1'b1, 6'd41, 1'b1, 1'b0, 1'b1});
    step('{1'b0, 1'b1, 6'd37, 1'b1, 6'd41, 1'b0, 1'b1, 1'b1});
    step('{1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1});
`else
    // Round robin after reset: both requesting alternates 0,1,0,1.
    step('{1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1});
    for (int i = 0; i < 4; i++)
      step('{1'b0, 1'b1, 6'(i), 1'b1, 6'(10 + i), (i % 2) == 0, (i % 2) == 1, 1'b1});
    step('{1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1});
`endif
    // Reset arriving in a would-be grant cycle: no grant and no response afterwards.
    step('{1'b0, 1'b1, 6'd7, 1'b0, 6'd0, 1'b1, 1'b0, 1'b1});
    step('{1'b1, 1'b1, 6'd8, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1});
    step('{1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1});
    step('{1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
